head_sprite_scheduler: RTL and testbench

Shares a single direction-stacked snake-head sprite ROM between the two players' heads on the VGA pixel path. For each pixel it decides which head, if any, covers the current (DrawX, DrawY) and arbitrates overlaps. It then drives the ROM address and returns a registered palette index tagged with the owning player. It sits between the VGA controller and the head palettes, and replaces one full ROM per player/orientation.

---
 rtl/head_sprite_scheduler.sv | 139 +++++++++++++
 tb/tb_head_sprite_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/head_sprite_scheduler.sv
// ============================================================================
// Module   : head_sprite_scheduler
// Function : Two-stage shared head-sprite ROM scheduler with overlap arbitration.
//            HEAD_PRIO_ROTATE_EN alternates overlap priority every frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module head_sprite_scheduler #(
  parameter int SPRITE_DIM = 24,
  parameter int ROM_AW     = 12,
  parameter int TRANSP_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        head_x0,
  input  logic [9:0]        head_y0,
  input  logic [9:0]        head_x1,
  input  logic [9:0]        head_y1,
  input  logic [1:0]        head_dir0,
  input  logic [1:0]        head_dir1,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pix_index,
  output logic              pix_player,
  output logic              pix_valid,
  output logic              heads_overlap,
  output logic              prio_player
);

  localparam logic [10:0]       DIM_C  = 11'(SPRITE_DIM);
  localparam logic [ROM_AW-1:0] DIM_A  = ROM_AW'(SPRITE_DIM);
  localparam logic [ROM_AW-1:0] SQ_A   = ROM_AW'(SPRITE_DIM * SPRITE_DIM);
  localparam logic [3:0]        TRANSP = 4'(TRANSP_IDX);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t state, state_next;
  logic   active;

  logic [9:0] sh_x0, sh_y0, sh_x1, sh_y1;
  logic [1:0] sh_dir0, sh_dir1;

  logic [10:0]       dx0, dy0, dx1, dy1, sel_dx, sel_dy;
  logic [1:0]        sel_dir;
  logic              hit0, hit1, any_hit, both_hit, winner;
  logic [ROM_AW-1:0] addr_next;

  logic s1_hit, s1_player, s1_blank;
  logic opaque, valid_next;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    active     = (state == ACTIVE);
    if (state == IDLE && frame_start) state_next = ACTIVE;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_x0 <= '0; sh_y0 <= '0; sh_dir0 <= '0;
      sh_x1 <= '0; sh_y1 <= '0; sh_dir1 <= '0;
    end else if (frame_start) begin
      sh_x0 <= head_x0; sh_y0 <= head_y0; sh_dir0 <= head_dir0;
      sh_x1 <= head_x1; sh_y1 <= head_y1; sh_dir1 <= head_dir1;
    end
  end

  // Widened to 11 bits: a pixel left of / above the head underflows to >= 1024.
  always_comb begin
    dx0      = {1'b0, DrawX} - {1'b0, sh_x0};
    dy0      = {1'b0, DrawY} - {1'b0, sh_y0};
    dx1      = {1'b0, DrawX} - {1'b0, sh_x1};
    dy1      = {1'b0, DrawY} - {1'b0, sh_y1};
    hit0     = active && (dx0 < DIM_C) && (dy0 < DIM_C);
    hit1     = active && (dx1 < DIM_C) && (dy1 < DIM_C);
    any_hit  = hit0 | hit1;
    both_hit = hit0 & hit1;
    winner   = both_hit ? prio_player : hit1;
    sel_dx   = winner ? dx1 : dx0;
    sel_dy   = winner ? dy1 : dy0;
    sel_dir  = winner ? sh_dir1 : sh_dir0;
    addr_next = ROM_AW'(sel_dir) * SQ_A + ROM_AW'(sel_dy) * DIM_A + ROM_AW'(sel_dx);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      s1_hit      <= 1'b0;
      s1_player   <= 1'b0;
      s1_blank    <= 1'b0;
    end else begin
      if (any_hit) rom_address <= addr_next;
      s1_hit    <= any_hit;
      s1_player <= winner;
      s1_blank  <= blank;
    end
  end

  always_comb begin
    opaque     = (rom_q != TRANSP);
    valid_next = s1_hit & s1_blank & opaque & active;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_index     <= '0;
      pix_player    <= 1'b0;
      pix_valid     <= 1'b0;
      heads_overlap <= 1'b0;
    end else begin
      pix_index  <= valid_next ? rom_q : 4'd0;
      pix_player <= s1_player;
      pix_valid  <= valid_next;
      if (frame_start)            heads_overlap <= 1'b0;
      else if (both_hit && blank) heads_overlap <= 1'b1;
    end
  end

`ifdef HEAD_PRIO_ROTATE_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)                 prio_player <= 1'b0;
    else if (frame_start && active) prio_player <= ~prio_player;
  end
`else
  assign prio_player = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_head_sprite_scheduler.sv
// ============================================================================
// Module   : tb_head_sprite_scheduler
// Function : Directed vector bench for head_sprite_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_head_sprite_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        blank = 1'b0;
  logic [9:0]  head_x0 = '0, head_y0 = '0, head_x1 = '0, head_y1 = '0;
  logic [1:0]  head_dir0 = '0, head_dir1 = '0;
  logic [11:0] rom_address;
  logic [3:0]  rom_q = '0;
  logic [3:0]  pix_index;
  logic        pix_player, pix_valid, heads_overlap, prio_player;

  int checks = 0;
  int failures = 0;
  logic exp_prio = 1'b0;
  logic started  = 1'b0;

  head_sprite_scheduler dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .head_x0(head_x0), .head_y0(head_y0), .head_x1(head_x1), .head_y1(head_y1),
    .head_dir0(head_dir0), .head_dir1(head_dir1),
    .rom_address(rom_address), .rom_q(rom_q),
    .pix_index(pix_index), .pix_player(pix_player), .pix_valid(pix_valid),
    .heads_overlap(heads_overlap), .prio_player(prio_player)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [9:0]  x0, y0; logic [1:0] d0;
    logic [9:0]  x1, y1; logic [1:0] d1;
    logic [9:0]  px, py; logic bl; logic [3:0] q;
    logic [11:0] addr; logic vld; logic [3:0] idx; logic pl;
  } vec_t;

  vec_t vecs[10];

  task automatic step(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Parks the pixel off both heads so the pulse itself cannot hit or overlap.
  task automatic pulse_frame();
    DrawX = 10'd0; DrawY = 10'd700; blank = 1'b0;
    step(1);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
`ifdef HEAD_PRIO_ROTATE_EN
    if (started) exp_prio = ~exp_prio;
`endif
    started = 1'b1;
  endtask

  task automatic set_heads(input logic [9:0] x0, y0, input logic [1:0] d0,
                           input logic [9:0] x1, y1, input logic [1:0] d1);
    head_x0 = x0; head_y0 = y0; head_dir0 = d0;
    head_x1 = x1; head_y1 = y1; head_dir1 = d1;
  endtask

  task automatic show(input logic [9:0] x, y, input logic bl, input logic [3:0] q);
    DrawX = x; DrawY = y; blank = bl; rom_q = q;
    step(3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr"},    32'(rom_address), 0);
    check({tag, "_index"},   32'(pix_index), 0);
    check({tag, "_player"},  32'(pix_player), 0);
    check({tag, "_valid"},   32'(pix_valid), 0);
    check({tag, "_overlap"}, 32'(heads_overlap), 0);
    check({tag, "_prio"},    32'(prio_player), 0);
  endtask

  initial begin
    //          x0    y0  d0   x1   y1  d1   px    py  bl  q   addr  v  idx pl
    vecs[0] = '{100,  50, 0,  600, 400, 0,  100,  50, 1, 5,     0, 1, 5, 0};
    vecs[1] = '{100,  50, 0,  200, 200, 3,  205, 210, 1, 7,  1973, 1, 7, 1};
    vecs[2] = '{100,  50, 1,  200, 200, 3,  123,  73, 1, 9,  1151, 1, 9, 0};
    vecs[3] = '{1015,  0, 0,  600, 400, 0,    5,   0, 1, 5,  1151, 0, 0, 0};
    vecs[4] = '{1015,  0, 2,  600, 400, 0, 1020,   3, 1, 4,  1229, 1, 4, 0};
    vecs[5] = '{1015,  0, 2,  600, 400, 0, 1020,   3, 1, 0,  1229, 0, 0, 0};
    vecs[6] = '{1015,  0, 2,  600, 400, 0, 1020,   3, 0, 4,  1229, 0, 0, 0};
    vecs[7] = '{0,     0, 0,  500, 500, 1,  524, 500, 1, 4,  1229, 0, 0, 0};
    vecs[8] = '{0,     0, 0,  500, 500, 1,  523, 523, 1, 3,  1151, 1, 3, 1};
    vecs[9] = '{0,     0, 0,  500, 500, 1,  499, 510, 1, 3,  1151, 0, 0, 0};

    step(2);
    check_zero("reset");
    reset_n = 1'b1;

    // Not yet started: a pixel on a head still produces nothing.
    set_heads(100, 50, 0, 600, 400, 0);
    show(100, 50, 1'b1, 4'd5);
    check("idle_valid", 32'(pix_valid), 0);
    check("idle_addr",  32'(rom_address), 0);

    for (int i = 0; i < 10; i++) begin
      set_heads(vecs[i].x0, vecs[i].y0, vecs[i].d0, vecs[i].x1, vecs[i].y1, vecs[i].d1);
      pulse_frame();
      show(vecs[i].px, vecs[i].py, vecs[i].bl, vecs[i].q);
      check($sformatf("v%0d_addr", i),  32'(rom_address), 32'(vecs[i].addr));
      check($sformatf("v%0d_valid", i), 32'(pix_valid), 32'(vecs[i].vld));
      check($sformatf("v%0d_index", i), 32'(pix_index), 32'(vecs[i].idx));
      if (vecs[i].vld) check($sformatf("v%0d_player", i), 32'(pix_player), 32'(vecs[i].pl));
      check($sformatf("v%0d_prio", i), 32'(prio_player), 32'(exp_prio));
    end

    // Mid-frame head move must not take effect before the next frame_start.
    set_heads(100, 50, 0, 600, 400, 0);
    pulse_frame();
    show(100, 50, 1'b1, 4'd6);
    check("mid_pre_valid", 32'(pix_valid), 1);
    head_x0 = 10'd400;
    show(100, 50, 1'b1, 4'd6);
    check("mid_hold_valid", 32'(pix_valid), 1);
    check("mid_hold_addr",  32'(rom_address), 0);
    check("mid_hold_index", 32'(pix_index), 6);
    pulse_frame();
    show(100, 50, 1'b1, 4'd6);
    check("mid_after_valid", 32'(pix_valid), 0);

    // Overlapping heads over three frames.
    set_heads(300, 300, 0, 310, 300, 0);
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      check($sformatf("ovl%0d_clear", f), 32'(heads_overlap), 0);
      show(315, 305, 1'b1, 4'd2);
      check($sformatf("ovl%0d_prio", f),   32'(prio_player), 32'(exp_prio));
      check($sformatf("ovl%0d_player", f), 32'(pix_player), 32'(exp_prio));
      check($sformatf("ovl%0d_addr", f),   32'(rom_address), exp_prio ? 125 : 135);
      check($sformatf("ovl%0d_valid", f),  32'(pix_valid), 1);
      check($sformatf("ovl%0d_set", f),    32'(heads_overlap), 1);
    end
`ifdef HEAD_PRIO_ROTATE_EN
    check("rotate_seq_end", 32'(exp_prio), 0);
`endif
    pulse_frame();
    check("ovl_final_clear", 32'(heads_overlap), 0);

    // Asynchronous reset in the middle of a line.
    show(315, 305, 1'b1, 4'd2);
    check("pre_rst_valid", 32'(pix_valid), 1);
    #1 reset_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_prio = 1'b0;
    started  = 1'b0;
    step(1);
    reset_n = 1'b1;
    show(315, 305, 1'b1, 4'd2);
    check("post_rst_valid", 32'(pix_valid), 0);
    check("post_rst_addr",  32'(rom_address), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
